// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_pkg
// Brief  : Default 640x480@60 raster constants and the shared coordinate type.
// Rev    : 1.0
// ============================================================================
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_VISIBLE  = 640;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_V_VISIBLE  = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;
  localparam int DEF_SYNC_DELAY = 2;

  // Sync windows are inclusive [START, END]
  localparam int H_TOTAL      = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL      = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic coord_t to_coord(input int value);
    return coord_t'(value);
  endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// ============================================================================
// Module : sync_delay_line
// Brief  : DEPTH-stage 1-bit shift register resetting to 1; DEPTH=0 is a wire.
// Rev    : 1.0
// ============================================================================
module sync_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = vga_clk ^ reset;
      assign q        = d;
    end else begin : g_shift
      logic [DEPTH-1:0] r_stage;

      always_ff @(posedge vga_clk) begin
        if (reset) begin
          r_stage <= '1;
        end else begin
          r_stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule : sync_delay_line
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_gen
// Brief  : VGA raster counters, active-video/event decodes and delayed syncs.
// Rev    : 1.0
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_end,
  output logic       frame_end
);

  localparam int LINE_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t HC_LAST  = to_coord(LINE_TOTAL - 1);
  localparam coord_t VC_LAST  = to_coord(FRAME_TOTAL - 1);
  localparam coord_t HC_VIS   = to_coord(H_VISIBLE);
  localparam coord_t VC_VIS   = to_coord(V_VISIBLE);
  localparam coord_t HS_START = to_coord(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END   = to_coord(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_START = to_coord(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END   = to_coord(V_VISIBLE + V_FRONT + V_SYNC - 1);

  coord_t r_hc;
  coord_t r_vc;
  logic   w_line_last;
  logic   w_frame_last;
  logic   w_hs_raw;
  logic   w_vs_raw;

  assign w_line_last  = (r_hc == HC_LAST);
  assign w_frame_last = w_line_last && (r_vc == VC_LAST);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_line_last) begin
      r_hc <= '0;
      r_vc <= (r_vc == VC_LAST) ? '0 : r_vc + 10'd1;
    end else begin
      r_hc <= r_hc + 10'd1;
    end
  end

  assign DrawX     = r_hc;
  assign DrawY     = r_vc;
  assign blank     = (r_hc < HC_VIS) && (r_vc < VC_VIS);
  assign line_end  = w_line_last;
  assign frame_end = w_frame_last;

  // vs decodes vc only, so it flips on the line wrap edge
  assign w_hs_raw = !((r_hc >= HS_START) && (r_hc <= HS_END));
  assign w_vs_raw = !((r_vc >= VS_START) && (r_vc <= VS_END));

  sync_delay_line #(
    .DEPTH (SYNC_DELAY)
  ) u_hs_dly (
    .vga_clk (vga_clk),
    .reset   (reset),
    .d       (w_hs_raw),
    .q       (hs)
  );

  sync_delay_line #(
    .DEPTH (SYNC_DELAY)
  ) u_vs_dly (
    .vga_clk (vga_clk),
    .reset   (reset),
    .d       (w_vs_raw),
    .q       (vs)
  );

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_timing_gen
// Brief  : Scoreboard bench: default (delay 2), zero-delay and miniature rasters.
// Rev    : 1.0
// ============================================================================
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;

  logic [9:0] dx, dy, dx0, dy0, sx, sy;
  logic bl, hs, vs, le, fe;
  logic bl0, hs0, vs0, le0, fe0;
  logic sbl, shs, svs, sle, sfe;

  vga_timing_gen dut (
    .vga_clk (vga_clk), .reset (reset), .DrawX (dx), .DrawY (dy), .blank (bl),
    .hs (hs), .vs (vs), .line_end (le), .frame_end (fe)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) dut0 (
    .vga_clk (vga_clk), .reset (reset), .DrawX (dx0), .DrawY (dy0), .blank (bl0),
    .hs (hs0), .vs (vs0), .line_end (le0), .frame_end (fe0)
  );

  // Miniature raster: 16 x 10 total, hs low hc 10..12, vs low vc 7..8
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(2)
  ) dut_s (
    .vga_clk (vga_clk), .reset (reset), .DrawX (sx), .DrawY (sy), .blank (sbl),
    .hs (shs), .vs (svs), .line_end (sle), .frame_end (sfe)
  );

  typedef struct {
    int         cyc;
    logic [9:0] x, y, x0, y0;
    logic       bl, hs, vs, le, fe, bl0, hs0, vs0;
    logic [9:0] sx, sy;
    logic       sbl, shs, svs, sle, sfe;
  } exp_t;

  exp_t sb[$];

  // Expected outputs k samples after counters left reset (k=0 is the reset state)
  function automatic exp_t make_exp(input int k);
    exp_t e;
    int x, y, mx, my, kd;
    x  = k % 800;
    y  = k / 800;
    mx = k % 16;
    my = (k / 16) % 10;
    kd = k - 2;
    e.cyc = 0;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.x0  = 10'(x);
    e.y0  = 10'(y);
    e.bl  = (x < 640) && (y < 480);
    e.bl0 = e.bl;
    e.le  = (x == 799);
    e.fe  = (x == 799) && (y == 524);
    e.hs  = !(x >= 658 && x <= 753);
    e.hs0 = !(x >= 656 && x <= 751);
    e.vs  = 1'b1;
    e.vs0 = 1'b1;
    e.sx  = 10'(mx);
    e.sy  = 10'(my);
    e.sbl = (mx < 8) && (my < 6);
    e.sle = (mx == 15);
    e.sfe = (mx == 15) && (my == 9);
    e.shs = (kd < 0) || !((kd % 16) >= 10 && (kd % 16) <= 12);
    e.svs = (kd < 0) || !(((kd / 16) % 10) == 7 || ((kd / 16) % 10) == 8);
    return e;
  endfunction

  task automatic push(input int k);
    exp_t e;
    e     = make_exp(k);
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops every expectation stamped for the current sample
  exp_t m;
  int   last_fe = -1, bl_cnt = 0, vs_run = 0;
  bit   bl_valid = 1'b0;

  initial forever begin
    @(negedge vga_clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m = sb.pop_front();
      if (m.cyc < cyc) begin
        chk("stale_entry", 16'(cyc), 16'(m.cyc));
      end else begin
        chk("DrawX", dx, m.x);        chk("DrawY", dy, m.y);
        chk("blank", bl, m.bl);       chk("hs", hs, m.hs);
        chk("vs", vs, m.vs);          chk("line_end", le, m.le);
        chk("frame_end", fe, m.fe);
        chk("DrawX_d0", dx0, m.x0);   chk("DrawY_d0", dy0, m.y0);
        chk("blank_d0", bl0, m.bl0);  chk("hs_d0", hs0, m.hs0);
        chk("vs_d0", vs0, m.vs0);
        chk("line_end_d0", le0, m.le); chk("frame_end_d0", fe0, m.fe);
        chk("s_DrawX", sx, m.sx);     chk("s_DrawY", sy, m.sy);
        chk("s_blank", sbl, m.sbl);   chk("s_hs", shs, m.shs);
        chk("s_vs", svs, m.svs);      chk("s_line_end", sle, m.sle);
        chk("s_frame_end", sfe, m.sfe);
      end
    end
    // Whole-frame properties of the miniature raster
    if (reset) begin
      last_fe  = -1;
      bl_cnt   = 0;
      bl_valid = 1'b0;
      vs_run   = 0;
    end else begin
      if (sbl) bl_cnt++;
      if (!svs) begin
        vs_run++;
      end else if (vs_run > 0) begin
        chk("s_vs_low_len", 16'(vs_run), 16'd32);
        vs_run = 0;
      end
      if (sfe) begin
        if (last_fe >= 0) chk("s_frame_period", 16'(cyc - last_fe), 16'd160);
        if (bl_valid) chk("s_blank_per_frame", 16'(bl_cnt), 16'd48);
        last_fe  = cyc;
        bl_cnt   = 0;
        bl_valid = 1'b1;
      end
    end
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge vga_clk); #1;
      push(0);
    end
    reset = 1'b0;

    // Three lines of the default raster; reset lands at DrawX=700, DrawY=2 inside an hs pulse
    for (int k = 1; k <= 2300; k++) begin
      @(posedge vga_clk); #1;
      push(k);
    end
    reset = 1'b1;
    @(posedge vga_clk); #1;
    push(0);
    reset = 1'b0;

    for (int k = 1; k <= 1700; k++) begin
      @(posedge vga_clk); #1;
      push(k);
    end

    for (int t = 0; t < 8 && sb.size() > 0; t++) @(posedge vga_clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_vga_timing_gen
`default_nettype wire
